// File: rtl/mux4_rr_sel_arbiter.sv
// mux4_rr_sel_arbiter
//   Upstream control stage for a 4:1 datapath mux. Four requesters are arbitrated
//   round-robin. The winner's index drives the mux select, and a valid/ready
//   handshake presents the selection downstream. While a transfer is stalled,
//   sel and gnt are held stable, so mux_out == in[sel] whenever out_valid is high.
//   A winner may keep the grant for up to MAX_BURST back-to-back transfers, as long
//   as it keeps requesting.
//
// Parameters
//   MAX_BURST  max consecutive transfers per grant (1..255)
//   CNT_W      burst counter width, 2**CNT_W > MAX_BURST
//
// Ports
//   clk        in   1  single clock, posedge
//   rst        in   1  synchronous active-high reset
//   req        in   4  request per source, bit i = mux input i
//   out_ready  in   1  downstream accepts the current selection
//   sel        out  2  mux select = index of granted source (registered)
//   gnt        out  4  one-hot grant, 0 when idle (registered)
//   out_valid  out  1  selection valid (registered)
module mux4_rr_sel_arbiter #(
  parameter int MAX_BURST = 1,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("mux4_rr_sel_arbiter: MAX_BURST must be in 1..255");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_BURST)) begin : g_bad_cnt_w
    $error("mux4_rr_sel_arbiter: CNT_W too narrow for MAX_BURST");
  end

  localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(MAX_BURST);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W:0]   cnt_inc;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_rearb;

  // Round-robin pick: search last+1, last+2, last+3, last (wrap).
  // Returns {found, index}. Iterating from farthest to nearest lets the
  // nearest requester overwrite the result, so it wins.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    cnt_inc    = {1'b0, cnt_q} + 1'b1;
    pick_idle  = rr_pick(ptr_q, req);
    // On release the finishing winner becomes the new pointer, so it is
    // searched last but can still be re-granted if it is the only requester.
    pick_rearb = rr_pick(sel_q, req);

    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick_idle[2]) begin
          state_d = BUSY;
          sel_d   = pick_idle[1:0];
          gnt_d   = 4'b0001 << pick_idle[1:0];
        end
      end
      BUSY: begin
        // Grant is locked until a transfer; req[sel] dropping alone does nothing.
        if (out_ready) begin
          if (req[sel_q] && (cnt_inc < BURST_LIM)) begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end else begin
            ptr_d = sel_q;
            cnt_d = '0;
            if (pick_rearb[2]) begin
              sel_d = pick_rearb[1:0];
              gnt_d = 4'b0001 << pick_rearb[1:0];
            end else begin
              state_d = IDLE;
              gnt_d   = 4'b0000;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign out_valid = (state_q == BUSY);

endmodule
